// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and FSM state type for the 8-input round-robin arbiter.
package rr_arb_pkg;

  localparam int IDX_W = 3;
  localparam int N_REQ = 1 << IDX_W;

  // One-hot encoding leaves unused codes that the FSM must steer back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    OFFER = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters, the arbiter and the index decoder.
// With RR_LOCK_EN defined the bundle also carries the burst-ownership lock bit.
interface rr_arbiter_8_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr;
`ifdef RR_LOCK_EN
  logic             lock;
`endif

`ifdef RR_LOCK_EN
  modport master (
    input  req, gnt_ready, lock,
    output gnt_valid, gnt_idx, ptr
  );
  modport slave (
    output req, gnt_ready, lock,
    input  gnt_valid, gnt_idx, ptr
  );
`else
  modport master (
    input  req, gnt_ready,
    output gnt_valid, gnt_idx, ptr
  );
  modport slave (
    output req, gnt_ready,
    input  gnt_valid, gnt_idx, ptr
  );
`endif

endinterface

// File: rtl/rr_arbiter_8_pick.sv
// Rotate-priority scan: first set request bit at or after start, wrapping mod N_REQ.
module rr_pick #(
  parameter int IDX_W = rr_arb_pkg::IDX_W,
  parameter int N_REQ = rr_arb_pkg::N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Walk from the farthest offset back to start so the nearest hit is written last.
  // N_REQ == 2**IDX_W, so the IDX_W-bit add wraps exactly like mod N_REQ.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = start + IDX_W'(i);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-input round-robin arbiter presenting the winner index under valid/ready.
// Optional RR_LOCK_EN adds a lock bit that keeps ownership across a handshake.
module rr_arbiter_8 #(
  parameter int IDX_W = rr_arb_pkg::IDX_W,
  parameter int N_REQ = rr_arb_pkg::N_REQ
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_arbiter_8_if.master      bus
);
  import rr_arb_pkg::state_t;
  import rr_arb_pkg::IDLE;
  import rr_arb_pkg::OFFER;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  state_t           state, next_state;
  logic             next_valid;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             handshake;
  logic [IDX_W-1:0] after_idx;

  assign handshake = (state == OFFER) && bus.gnt_valid && bus.gnt_ready;
  assign after_idx = bus.gnt_idx + ONE;

  // One shared scanner: fresh arbitration from ptr when idle, rescan on handshake.
  always_comb begin
    pick_start = bus.ptr;
    if (handshake) begin
`ifdef RR_LOCK_EN
      pick_start = bus.lock ? bus.gnt_idx : after_idx;
`else
      pick_start = after_idx;
`endif
    end
  end

  rr_pick #(
    .IDX_W (IDX_W),
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (bus.req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    next_state = state;
    next_valid = bus.gnt_valid;
    next_idx   = bus.gnt_idx;
    next_ptr   = bus.ptr;

    case (state)
      IDLE: begin
        next_valid = 1'b0;
        if (pick_found) begin
          next_state = OFFER;
          next_valid = 1'b1;
          next_idx   = pick_idx;
        end
      end

      OFFER: begin
        // Grant is sticky: nothing on req matters until the offer is taken.
        if (handshake) begin
`ifdef RR_LOCK_EN
          next_ptr = bus.lock ? bus.ptr : after_idx;
`else
          next_ptr = after_idx;
`endif
          if (pick_found) begin
            next_idx = pick_idx;
          end else begin
            next_state = IDLE;
            next_valid = 1'b0;
          end
        end
      end

      default: begin
        next_state = IDLE;
        next_valid = 1'b0;
      end
    endcase
  end

  // Reset is synchronous: it is only seen on a rising edge and drops any offer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state         <= IDLE;
      bus.gnt_valid <= 1'b0;
      bus.gnt_idx   <= '0;
      bus.ptr       <= '0;
    end else begin
      state         <= next_state;
      bus.gnt_valid <= next_valid;
      bus.gnt_idx   <= next_idx;
      bus.ptr       <= next_ptr;
    end
  end

endmodule
